// File: rtl/onehot_serial_encoder.sv
// onehot_serial_encoder
//
// Serializing priority encoder. A request vector is accepted through a
// valid/ready handshake. The binary index of every set bit is then emitted,
// lowest index first, one index per cycle through a second valid/ready
// handshake.
//
// Parameters:
//   encode_width  width of the emitted index
//   decode_width  width of the request vector (2 .. 1 << encode_width)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in holds a vector to accept
//   in_ready   block can accept a vector this cycle (IDLE)
//   in         request vector; bit i set => index i is emitted
//   out_valid  out holds a valid index (SCAN)
//   out_ready  consumer takes out this cycle
//   out        index of the lowest pending set bit
//   out_last   current index is the final one of the vector
//   remaining  pending index count, including the current one
module onehot_serial_encoder #(
  parameter int encode_width = 4,
  parameter int decode_width = 1 << encode_width
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [decode_width-1:0] in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [encode_width-1:0] out,
  output logic                    out_last,
  output logic [encode_width:0]   remaining
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [decode_width-1:0] r_pending;
  logic [decode_width-1:0] w_pending_next;
  logic [encode_width-1:0] r_out;
  logic [encode_width-1:0] w_out_next;
  logic [encode_width:0]   r_remaining;
  logic [encode_width:0]   w_remaining_next;
  logic                    r_last;
  logic                    w_last_next;
  logic [decode_width-1:0] w_cleared;
  logic [encode_width:0]   w_in_count;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [encode_width-1:0] f_lowest(input logic [decode_width-1:0] v);
    logic [encode_width-1:0] idx;
    idx = '0;
    for (int i = decode_width - 1; i >= 0; i--) begin
      if (v[i]) idx = encode_width'(i);
    end
    return idx;
  endfunction

  // Number of set bits; one extra bit so an all-ones vector fits.
  function automatic logic [encode_width:0] f_popcount(input logic [decode_width-1:0] v);
    logic [encode_width:0] cnt;
    cnt = '0;
    for (int i = 0; i < decode_width; i++) begin
      cnt = cnt + (encode_width + 1)'(v[i]);
    end
    return cnt;
  endfunction

  assign w_in_count = f_popcount(in);
  // Pending bits once the currently presented index has been consumed.
  assign w_cleared  = r_pending & ~(decode_width'(1) << r_out);

  // The next presented index, count and last flag are computed one cycle
  // ahead so that out/out_last/remaining come straight from registers.
  always_comb begin
    w_state_next     = r_state;
    w_pending_next   = r_pending;
    w_out_next       = r_out;
    w_remaining_next = r_remaining;
    w_last_next      = r_last;
    case (r_state)
      S_IDLE: begin
        // A zero vector is accepted and dropped: nothing changes.
        if (in_valid && (in != '0)) begin
          w_state_next     = S_SCAN;
          w_pending_next   = in;
          w_out_next       = f_lowest(in);
          w_remaining_next = w_in_count;
          w_last_next      = (w_in_count == (encode_width + 1)'(1));
        end
      end
      S_SCAN: begin
        if (out_ready) begin
          if (r_last) begin
            // Back to IDLE with all presented outputs forced to zero.
            w_state_next     = S_IDLE;
            w_pending_next   = '0;
            w_out_next       = '0;
            w_remaining_next = '0;
            w_last_next      = 1'b0;
          end else begin
            w_pending_next   = w_cleared;
            w_out_next       = f_lowest(w_cleared);
            w_remaining_next = r_remaining - (encode_width + 1)'(1);
            w_last_next      = (r_remaining == (encode_width + 1)'(2));
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_out       <= '0;
      r_remaining <= '0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pending   <= w_pending_next;
      r_out       <= w_out_next;
      r_remaining <= w_remaining_next;
      r_last      <= w_last_next;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_SCAN);
  assign out       = r_out;
  assign out_last  = r_last;
  assign remaining = r_remaining;

endmodule

// File: tb/tb_onehot_serial_encoder.sv
module tb_onehot_serial_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic        out_last;
  logic [4:0]  remaining;

  int checks;
  int failures;

  onehot_serial_encoder #(
    .encode_width(4),
    .decode_width(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_idx),
    .out_last  (out_last),
    .remaining (remaining)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d req=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: the expected beat stream is simply the list of set-bit
  // positions in ascending order; remaining counts down from its length.
  // Called at a negedge while the DUT should be idle.
  task automatic run_vector(input logic [15:0] vec, input int stall_pct,
                            output int first_out, output int first_rem,
                            output int last_out);
    int exp_idx[$];
    int n;
    int k;
    int guard;
    exp_idx   = {};
    first_out = -1;
    first_rem = -1;
    last_out  = -1;
    for (int i = 0; i < 16; i++) if (vec[i]) exp_idx.push_back(i);
    n = exp_idx.size();
    check("accept_in_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_vec    = vec;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_vec   = 16'($urandom);
    if (n == 0) begin
      check("zero_out_valid", 32'(out_valid), 32'd0);
      check("zero_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      check("zero_out_valid2", 32'(out_valid), 32'd0);
      check("zero_in_ready2", 32'(in_ready), 32'd1);
      return;
    end
    k = 0;
    guard = 0;
    while (k < n && guard < 400) begin
      check("beat_valid", 32'(out_valid), 32'd1);
      check("beat_in_ready", 32'(in_ready), 32'd0);
      check("beat_idx", 32'(out_idx), 32'(exp_idx[k]));
      check("beat_remaining", 32'(remaining), 32'(n - k));
      check("beat_last", 32'(out_last), 32'(k == n - 1));
      if (k == 0) begin
        first_out = int'(out_idx);
        first_rem = int'(remaining);
      end
      out_ready = ($urandom_range(99) >= stall_pct);
      in_vec    = 16'($urandom);
      in_valid  = 1'($urandom);
      if (out_ready && out_last) last_out = int'(out_idx);
      @(negedge clk);
      if (out_ready) k++;
      guard++;
    end
    if (k < n) check("beat_timeout", 32'(k), 32'(n));
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("rearm_in_ready", 32'(in_ready), 32'd1);
    check("rearm_out_valid", 32'(out_valid), 32'd0);
    check("rearm_out", 32'(out_idx), 32'd0);
    check("rearm_remaining", 32'(remaining), 32'd0);
  endtask

  typedef struct {
    logic [15:0] vec;
    int          count;
    int          first_idx;
    int          last_idx;
  } vec_rec_t;

  vec_rec_t vtab[7];

  initial begin
    int fo, fr, lo;
    checks    = 0;
    failures  = 0;

    vtab[0] = '{16'h8421, 4, 0, 15};
    vtab[1] = '{16'hFFFF, 16, 0, 15};
    vtab[2] = '{16'h0001, 1, 0, 0};
    vtab[3] = '{16'h8000, 1, 15, 15};
    vtab[4] = '{16'h0006, 2, 1, 2};
    vtab[5] = '{16'h0000, 0, -1, -1};
    vtab[6] = '{16'hA000, 2, 13, 15};

    // Reset with random inputs applied
    rst       = 1'b1;
    in_valid  = 1'($urandom);
    in_vec    = 16'($urandom);
    out_ready = 1'($urandom);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out", 32'(out_idx), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_remaining", 32'(remaining), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      in_valid  = 1'($urandom);
      in_vec    = 16'($urandom);
      out_ready = 1'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_out", 32'(out_idx), 32'd0);
    check("post_rst_out_last", 32'(out_last), 32'd0);
    check("post_rst_remaining", 32'(remaining), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors, full throughput
    for (int t = 0; t < 7; t++) begin
      run_vector(vtab[t].vec, 0, fo, fr, lo);
      $display("vector %h: first_out=%0d first_rem=%0d last_out=%0d", vtab[t].vec, fo, fr, lo);
      if (vtab[t].count > 0) begin
        check("tab_first_idx", 32'(fo), 32'(vtab[t].first_idx));
        check("tab_count", 32'(fr), 32'(vtab[t].count));
        check("tab_last_idx", 32'(lo), 32'(vtab[t].last_idx));
      end
    end

    // Backpressure: 0006, out_ready low for 3 cycles, in toggled during SCAN
    in_valid = 1'b1;
    in_vec   = 16'h0006;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_idx", 32'(out_idx), 32'd1);
      check("bp_remaining", 32'(remaining), 32'd2);
      check("bp_last", 32'(out_last), 32'd0);
      in_vec    = ~in_vec;
      in_valid  = 1'b1;
      out_ready = (c == 3);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    check("bp2_valid", 32'(out_valid), 32'd1);
    check("bp2_idx", 32'(out_idx), 32'd2);
    check("bp2_remaining", 32'(remaining), 32'd1);
    check("bp2_last", 32'(out_last), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_rearm", 32'(in_ready), 32'd1);
    check("bp_done_valid", 32'(out_valid), 32'd0);
    $display("backpressure sequence 0006 done");

    // Async reset mid-scan: 00F0, reset after 2 beats
    in_valid  = 1'b1;
    in_vec    = 16'h00F0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ar_pre_idx", 32'(out_idx), 32'd6);
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out", 32'(out_idx), 32'd0);
    check("ar_remaining", 32'(remaining), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ar_idle_valid", 32'(out_valid), 32'd0);
    run_vector(16'h0003, 0, fo, fr, lo);
    check("ar_post_first", 32'(fo), 32'd0);
    check("ar_post_last", 32'(lo), 32'd1);
    $display("async reset sequence done: first=%0d last=%0d", fo, lo);

    // Randomized vectors and backpressure against the reference queue
    for (int r = 0; r < 60; r++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if (r % 3 == 1) v = v & 16'($urandom) & 16'($urandom);
      if (r % 17 == 5) v = 16'h0000;
      run_vector(v, int'($urandom_range(60)), fo, fr, lo);
      $display("random vector %h: first_out=%0d first_rem=%0d last_out=%0d", v, fo, fr, lo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onehot_serial_encoder.md
# onehot_serial_encoder

Serializing priority encoder: the inverse of the team's one-hot decoder. Accepts a `decode_width`-bit request vector through a valid/ready handshake. Emits the binary index of every set bit, one index per cycle, lowest index first, through a second valid/ready handshake. Sits between status/request bit-vector producers and consumers that take a binary select (for example, the decoder's `in`).

## Interface
- `encode_width`, default 4: width of the emitted index.
- `decode_width`, default `1 << encode_width`: width of the input vector. Legal range is 2..`1 << encode_width`.
- `clk` input, 1 bit: the single clock. All state updates on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: `in` holds a vector to accept.
- `in_ready` output, 1 bit: block can accept a vector this cycle.
- `in` input, `decode_width` bits: request vector. Bit i set means index i is to be emitted.
- `out_valid` output, 1 bit: `out` holds a valid index.
- `out_ready` input, 1 bit: the consumer takes `out` this cycle.
- `out` output, `encode_width` bits: binary index of the lowest pending set bit.
- `out_last` output, 1 bit: the current index is the final one of the vector.
- `remaining` output, `encode_width+1` bits: number of pending indices, including the current one.

## Operation
- There are two states, IDLE and SCAN. A `decode_width`-bit register `pending` holds the bits not yet emitted.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid && in_ready` with `in` != 0: `pending` <= `in`, `remaining` <= popcount(`in`), go to SCAN.
  - On `in_valid && in_ready` with `in` == 0: the vector is accepted and discarded. No output beat is produced and the block stays in IDLE.
- SCAN:
  - `in_ready`=0, `out_valid`=1.
  - `out` = index of the lowest set bit of `pending`.
  - `out_last` = (`remaining` == 1).
- Output handshake in SCAN: on `out_valid && out_ready`, clear bit `out` in `pending` and decrement `remaining`. If `out_last`=1, go to IDLE; `pending` is then 0.
- `out`, `out_last` and `remaining` are driven from registers only, with no combinational path from `in`, `in_valid` or `out_ready`.
- When `out_valid`=0: `out`=0, `out_last`=0, `remaining`=0.
- Width rule: `remaining` is `encode_width+1` bits so that an all-ones vector is counted exactly. With defaults, 16'hFFFF gives 5'd16.

## Timing
- Reset:
  - Asserting `rst` immediately forces IDLE and `pending`=0.
  - Outputs during reset: `out_valid`=0, `out`=0, `out_last`=0, `remaining`=0, `in_ready`=1.
  - Reset mid-SCAN abandons the vector. No further beats from it are emitted.
- After `rst` deasserts, the first vector is accepted on the first rising edge with `in_valid`=1.
- Latency: vector accepted at edge N gives the first index valid in the cycle after edge N.
- Throughput: one index per cycle while `out_ready`=1. A vector with k set bits occupies k cycles of SCAN.
- Backpressure: while `out_valid && !out_ready`, `out`, `out_last`, `remaining` and `pending` hold stable.
- Re-arm: `in_ready` returns to 1 in the cycle after the handshake of the `out_last` beat. There is exactly one bubble cycle between vectors.
- `in` is sampled only on the accepting edge. Changes to `in` during SCAN are ignored.
- A single-bit vector produces one beat with `out_last`=1 and `remaining`=1.

## Test plan
- Reset values: assert `rst` with random inputs applied. Check `out_valid`=0, `out`=0, `out_last`=0, `remaining`=0, `in_ready`=1, both during and after reset.
- Sparse vector: `in`=16'h8421 with `out_ready`=1.
  - `out` = 0, 5, 10, 15 on four consecutive cycles.
  - `remaining` = 4, 3, 2, 1.
  - `out_last` is high only on 15.
  - `in_ready`=1 on the following cycle.
- Backpressure: `in`=16'h0006 with `out_ready`=0 for 3 cycles, then 1.
  - `out`=1 with `remaining`=2 held for 4 cycles.
  - Then `out`=2 with `out_last`=1.
  - Toggle `in` during SCAN; no effect is allowed.
- Zero vector: `in`=16'h0000 with `in_valid`=1. `out_valid` stays 0 and `in_ready` stays 1 throughout.
- Full vector: `in`=16'hFFFF.
  - 16 beats with `out` = 0..15 and `remaining` = 16..1.
  - `remaining` shows 5'b10000 on the first beat.
- Async reset mid-scan: `in`=16'h00F0, assert `rst` asynchronously after 2 beats.
  - `out_valid` drops without waiting for a clock edge.
  - After release, `in`=16'h0003 yields exactly indices 0 then 1.
